// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide, synchronous-read main-memory port between
// instruction fetch and the load/store buffer. It arbitrates in IDLE, splits
// each access into byte beats, assembles and extends load data, and pulses one
// done per access.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global freeze), clear_in (flush)
//   if_req/if_addr            -> if_done/if_inst      fetch side (32-bit LE word)
//   lsb_req/is_load/funct3/addr/wdata -> lsb_welcome/lsb_done/lsb_rdata
//   mem_din <- RAM; mem_dout/mem_a/mem_wr -> RAM
//   io_buffer_full            I/O write buffer full
//
// Optional feature: define MEM_ARB_IO_STALL_EN to stall store beats aimed at an
// I/O address while io_buffer_full is high.
module mem_arbiter #(
  parameter int unsigned IO_SEL_HI = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        lsb_req,
  input  logic        lsb_is_load,
  input  logic [2:0]  lsb_funct3,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_welcome,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_lsb_q, last_lsb_d;
  logic        squash_q, squash_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic        grant_lsb, grant_if, io_stall;
  logic [2:0]  beats, cnt_inc;
  logic [1:0]  rd_idx;

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3);
    unique case (f3)
      3'd0:    load_ext = {{24{d[7]}}, d[7:0]};
      3'd1:    load_ext = {{16{d[15]}}, d[15:0]};
      3'd4:    load_ext = {24'd0, d[7:0]};
      3'd5:    load_ext = {16'd0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  assign lsb_welcome = (state_q == StIdle) && !clear_in && rdy_in;
  // On a tie the requester not served last wins.
  assign grant_lsb   = lsb_welcome && lsb_req && (!if_req || !last_lsb_q);
  assign grant_if    = (state_q == StIdle) && !clear_in && rdy_in && if_req && !grant_lsb;

  assign beats   = (funct3_q[1:0] == 2'd0) ? 3'd1 : (funct3_q[1:0] == 2'd1) ? 3'd2 : 3'd4;
  assign cnt_inc = cnt_q + 3'd1;
  // Byte arriving now was addressed one beat earlier than cnt_q.
  assign rd_idx  = cnt_q[1:0] - 2'd1;

`ifdef MEM_ARB_IO_STALL_EN
  assign io_stall = (state_q == StStore) && (mem_a_q[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    base_d      = base_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    last_lsb_d  = last_lsb_q;
    squash_d    = squash_q;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_lsb) begin
          last_lsb_d = 1'b1;
          base_d     = lsb_addr;
          funct3_d   = lsb_funct3;
          wdata_d    = lsb_wdata;
          cnt_d      = '0;
          buf_d      = '0;
          squash_d   = 1'b0;
          mem_a_d    = lsb_addr;
          if (lsb_is_load) begin
            state_d = StLoad;
          end else begin
            state_d    = StStore;
            mem_dout_d = lsb_wdata[7:0];
            mem_wr_d   = 1'b1;
          end
        end else if (grant_if) begin
          last_lsb_d = 1'b0;
          base_d     = if_addr;
          funct3_d   = 3'd2;
          cnt_d      = '0;
          buf_d      = '0;
          mem_a_d    = if_addr;
          state_d    = StFetch;
        end
      end
      StFetch, StLoad: begin
        if (clear_in) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
          if (cnt_q == beats) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (state_q == StFetch) begin
              if_done_d = 1'b1;
              if_inst_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = load_ext(buf_d, funct3_q);
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < beats) mem_a_d = base_q + {29'd0, cnt_inc};
          end
        end
      end
      StStore: begin
        // Writes already issued cannot be recalled, so a flush only hides done.
        squash_d = squash_q | clear_in;
        if (io_stall) begin
          mem_wr_d = 1'b1;
        end else if (cnt_inc < beats) begin
          cnt_d      = cnt_inc;
          mem_a_d    = base_q + {29'd0, cnt_inc};
          mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end else begin
          state_d     = StIdle;
          cnt_d       = '0;
          lsb_done_d  = !(squash_q || clear_in);
          lsb_rdata_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      buf_q       <= '0;
      base_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      last_lsb_q  <= 1'b0;
      squash_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_inst_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      base_q      <= base_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      last_lsb_q  <= last_lsb_d;
      squash_q    <= squash_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q && rdy_in && !io_stall;

endmodule
